// File: rtl/dis_field_process_data_if.sv
// Avalon-ST video stream between the pipeline output and the display front-end.
`timescale 1ns/1ps
interface dis_field_process_data_if #(
    parameter int unsigned W = 10
);
    logic [W-1:0] vst_data;
    logic         vst_valid;
    logic         vst_ready;
    logic         vst_startofpacket;
    logic         vst_endofpacket;

    modport master (
        output vst_data, vst_valid, vst_startofpacket, vst_endofpacket,
        input  vst_ready
    );

    modport slave (
        input  vst_data, vst_valid, vst_startofpacket, vst_endofpacket,
        output vst_ready
    );
endinterface

// File: rtl/dis_field_process_data.sv
// Display front-end: decodes Avalon-ST video packets and writes field-selected
// lines into the display FIFO, paced by a free-running field timer with resync.
`timescale 1ns/1ps
module dis_field_process_data #(
    parameter int unsigned DATA_WIDTH   = 10,
    parameter int unsigned CHANNELS     = 1,
    parameter int unsigned LINE_BEATS   = 720,
    parameter int unsigned FRAME_LINES  = 576,
    parameter int unsigned INTERLACED   = 1,
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned FIELD_PERIOD = 1_000_000,
    parameter int unsigned PRE_WINDOW   = 3_200,
    parameter int unsigned FIFO_AW      = 10,
    parameter int unsigned FIFO_LEVEL   = 720,
    parameter int unsigned CLR_LEAD     = 8,
    parameter int unsigned RESYNC_HOLD  = 15
) (
    input  logic                           vst_clk,
    input  logic                           vst_rst,
    dis_field_process_data_if.slave        vst,
    output logic [DATA_WIDTH*CHANNELS-1:0] fifo_data,
    output logic                           fifo_wrreq,
    input  logic [FIFO_AW-1:0]             fifo_usedw,
    output logic                           fifo_aclr,
    output logic                           dis_rst,
    output logic                           field_id,
    output logic [15:0]                    resync_cnt
);
    localparam int unsigned PERIOD = (INTERLACED != 0) ? 2 * FIELD_PERIOD : FIELD_PERIOD;
    localparam int unsigned XW     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int unsigned YW     = 10;
    localparam int unsigned HW     = (RESYNC_HOLD > 0) ? $clog2(RESYNC_HOLD + 1) : 1;

    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] T_F1   = CNT_W'(FIELD_PERIOD);
    localparam logic [CNT_W-1:0] T_PRE0 = CNT_W'(PRE_WINDOW);
    localparam logic [CNT_W-1:0] T_PRE1 = CNT_W'(FIELD_PERIOD + PRE_WINDOW);
    localparam logic [CNT_W-1:0] T_CLR0 = CNT_W'(FIELD_PERIOD - CLR_LEAD);
    localparam logic [CNT_W-1:0] T_CLR1 = CNT_W'(PERIOD - CLR_LEAD);
    localparam logic [XW-1:0]    X_LAST = XW'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VIDEO,
        S_DROP
    } pkt_state_e;

    pkt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [15:0]       resync_q, resync_d;
    logic              field_q, aclr_q, dis_rst_q;

    logic accept, sop, eop, hdr_video, in_pre, hold_idle, line_ok, line_sel, resync_trig;

    assign sop       = vst.vst_startofpacket;
    assign eop       = vst.vst_endofpacket;
    assign accept    = vst.vst_valid & vst.vst_ready;
    assign hdr_video = (vst.vst_data[3:0] == 4'h0);
    assign hold_idle = (hold_q == '0);
    assign line_ok   = (32'(y_q) < FRAME_LINES);
    assign line_sel  = (INTERLACED != 0) ? (y_q[0] == field_q) : 1'b1;

    // Pre-phases are the windows at the start of each field where filling is always allowed.
    assign in_pre = (timer_q < T_PRE0)
                  | ((INTERLACED != 0) & (timer_q >= T_F1) & (timer_q < T_PRE1));

    // A video header arriving outside a pre-phase means the source is late: resync.
    assign resync_trig = accept & sop & hdr_video & ~in_pre & hold_idle;

    assign vst.vst_ready = ~vst_rst
                         & (32'(fifo_usedw) <= FIFO_LEVEL)
                         & ((state_q != S_VIDEO) | in_pre | line_ok)
                         & hold_idle;

    assign fifo_data  = vst.vst_data;
    assign fifo_wrreq = accept & (state_q == S_VIDEO) & ~sop & line_ok & line_sel;
    assign fifo_aclr  = aclr_q;
    assign dis_rst    = dis_rst_q;
    assign field_id   = field_q;
    assign resync_cnt = resync_q;

    // Packet FSM and pixel position, advanced only on accepted beats.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (accept) begin
            if (sop) begin
                state_d = eop ? S_IDLE : (hdr_video ? S_VIDEO : S_DROP);
                if (hdr_video) begin
                    x_d = '0;
                    y_d = '0;
                end
            end else if (state_q == S_VIDEO) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q != '1) y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
                if (eop) state_d = S_IDLE;
            end else if (eop) begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        timer_d  = (resync_trig | ~hold_idle | (timer_q == T_LAST)) ? '0 : timer_q + CNT_W'(1);
        hold_d   = resync_trig ? HW'(RESYNC_HOLD) : (hold_idle ? '0 : hold_q - HW'(1));
        resync_d = (resync_trig & (resync_q != 16'hFFFF)) ? resync_q + 16'd1 : resync_q;
    end

    always_ff @(posedge vst_clk) begin
        if (vst_rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            hold_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            resync_q  <= '0;
            field_q   <= 1'b0;
            aclr_q    <= 1'b1;
            dis_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            hold_q    <= hold_d;
            x_q       <= x_d;
            y_q       <= y_d;
            resync_q  <= resync_d;
            field_q   <= (INTERLACED != 0) & (timer_q >= T_F1);
            aclr_q    <= hold_idle & ((timer_q == T_CLR0) | (timer_q == T_CLR1));
            dis_rst_q <= ~hold_idle;
        end
    end
endmodule
